output_port_credit_tx: RTL and testbench

Transmit-side leaf port: the sending end of the credit-based link whose receiving end is the leaf's Input_Port. It accepts payload beats from the user operator over a vld/ack handshake and buffers them in a local FIFO. It packetizes each beat toward the destination leaf/port held in its control register and presents packets to the leaf interface arbiter. Transmission is gated by a credit counter, which mirrors free BRAM space at the remote input port and is refilled by freespace-update packets arriving on stream_in.

---
 rtl/output_port_credit_tx_pkg.sv | 20 ++
 rtl/output_port_credit_tx_sync_fifo_fwft.sv | 38 +++
 rtl/output_port_credit_tx.sv | 98 +++++++++
 tb/tb_output_port_credit_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_port_credit_tx_pkg.sv
// output_port_credit_tx_pkg: packet layout, credit and FSM constants shared by the leaf port blocks
// Holds the default field widths and bit offsets of a BFT packet (also used by Input_Port),
// the transmit FSM state encoding, and the credit ceiling helper.
package output_port_credit_tx_pkg;
  localparam int PKT_BITS = 97;
  localparam int PKT_LEAF_BITS = 6;
  localparam int PKT_PORT_BITS = 4;
  localparam int PKT_ADDR_BITS = 7;
  localparam int PKT_PAYLOAD_BITS = 64;
  localparam int PKT_VLD_POS = PKT_BITS - 1;
  localparam int PKT_DST_LSB = PKT_VLD_POS - PKT_LEAF_BITS - PKT_PORT_BITS;
  localparam int PKT_SRC_LSB = PKT_DST_LSB - PKT_LEAF_BITS - PKT_PORT_BITS;
  localparam int PKT_ADDR_LSB = PKT_SRC_LSB - PKT_ADDR_BITS;
  localparam int PKT_PAYLOAD_LSB = 0;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;
  function automatic int credit_max(input int bram_addr_bits);
    return 1 << bram_addr_bits;
  endfunction
endpackage

// File: rtl/output_port_credit_tx_sync_fifo_fwft.sv
// output_port_credit_tx_sync_fifo_fwft: first-word-fall-through synchronous FIFO
// Ports: clk/reset (sync, active-low); push/din write side; pop/dout read side (dout valid
//   whenever !empty); count (0..2^ADDR_BITS), full, empty status.
module output_port_credit_tx_sync_fifo_fwft #(
  parameter int WIDTH = 32,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [WIDTH-1:0]     din,
  input  logic                 pop,
  output logic [WIDTH-1:0]     dout,
  output logic [ADDR_BITS:0]   count,
  output logic                 full,
  output logic                 empty
);
  logic [WIDTH-1:0] mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  assign full = count[ADDR_BITS];
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_BITS'(do_push);
      rd_ptr <= rd_ptr + ADDR_BITS'(do_pop);
      count <= count + (ADDR_BITS+1)'(do_push) - (ADDR_BITS+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/output_port_credit_tx.sv
// output_port_credit_tx: credit-gated transmit leaf port packetizing user beats toward a remote input port
// Ports: clk/reset (sync, active-low); self_leaf, out_control_reg {dst_leaf,dst_port};
//   din_user/vld_user2b_out/ack_b_out2user user beat handshake; stream_in carries freespace updates;
//   packet_out/packet_out_vld/packet_out_ack arbiter handshake; credit_cnt, sent_cnt, stall_cnt,
//   output_port_stall_condition and sticky credit_err report status.
module output_port_credit_tx
  import output_port_credit_tx_pkg::*;
#(
  parameter int PACKET_BITS = PKT_BITS,
  parameter int NUM_LEAF_BITS = PKT_LEAF_BITS,
  parameter int NUM_PORT_BITS = PKT_PORT_BITS,
  parameter int NUM_ADDR_BITS = PKT_ADDR_BITS,
  parameter int PAYLOAD_BITS = PKT_PAYLOAD_BITS,
  parameter int NUM_BRAM_ADDR_BITS = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int FIFO_ADDR_BITS = 4,
  parameter int PORT_No = 2,
  parameter int DATA_USER_OUT = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_LEAF_BITS-1:0]             self_leaf,
  input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0] out_control_reg,
  input  logic [DATA_USER_OUT-1:0]             din_user,
  input  logic                                 vld_user2b_out,
  output logic                                 ack_b_out2user,
  input  logic [PACKET_BITS-1:0]               stream_in,
  output logic [PACKET_BITS-1:0]               packet_out,
  output logic                                 packet_out_vld,
  input  logic                                 packet_out_ack,
  output logic [NUM_BRAM_ADDR_BITS:0]          credit_cnt,
  output logic [PAYLOAD_BITS-1:0]              sent_cnt,
  output logic [PAYLOAD_BITS-1:0]              stall_cnt,
  output logic                                 output_port_stall_condition,
  output logic                                 credit_err
);
  localparam int CTRL_BITS = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int VLD_POS = PACKET_BITS - 1;
  localparam int DST_LSB = VLD_POS - CTRL_BITS;
  localparam int SRC_LSB = DST_LSB - CTRL_BITS;
  localparam int PAD_BITS = SRC_LSB - NUM_ADDR_BITS - PAYLOAD_BITS;
  localparam int CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;
  localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = CREDIT_BITS'(credit_max(NUM_BRAM_ADDR_BITS));
  localparam logic [NUM_PORT_BITS-1:0] PORT_ID = NUM_PORT_BITS'(PORT_No);
  logic [DATA_USER_OUT-1:0] fifo_dout;
  logic [FIFO_ADDR_BITS:0] fifo_count;
  logic fifo_full, fifo_empty, load, upd_hit, upd_q, over, unused;
  logic [0:0] state;
  logic [NUM_ADDR_BITS-1:0] bram_addr;
  logic [CREDIT_BITS:0] credit_sum;
  output_port_credit_tx_sync_fifo_fwft #(.WIDTH(DATA_USER_OUT), .ADDR_BITS(FIFO_ADDR_BITS)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(vld_user2b_out && ack_b_out2user),
    .din(din_user),
    .pop(load),
    .dout(fifo_dout),
    .count(fifo_count),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  assign unused = ^stream_in[SRC_LSB-1:0];
  assign ack_b_out2user = !fifo_full;
  assign packet_out_vld = state == ST_SEND;
  assign output_port_stall_condition = fifo_count != '0 && credit_cnt == '0;
  // In SEND a new packet may only be loaded in the cycle the current one is accepted.
  assign load = !fifo_empty && credit_cnt != '0 && (state == ST_IDLE || packet_out_ack);
  // A freespace update is addressed to us and originates from the port we transmit to.
  assign upd_hit = stream_in[VLD_POS] && stream_in[DST_LSB +: CTRL_BITS] == {self_leaf, PORT_ID}
                   && stream_in[SRC_LSB +: CTRL_BITS] == out_control_reg;
  // One extra bit of headroom so an over-return is visible before clamping; load implies credit>0.
  assign credit_sum = {1'b0, credit_cnt} + (upd_q ? (CREDIT_BITS+1)'(FREESPACE_UPDATE_SIZE) : '0)
                      - (CREDIT_BITS+1)'(load);
  assign over = credit_sum > {1'b0, CREDIT_MAX};
  always_ff @(posedge clk)
    if (!reset) begin
      state <= ST_IDLE;
      packet_out <= '0;
      credit_cnt <= CREDIT_MAX;
      bram_addr <= '0;
      upd_q <= 1'b0;
      sent_cnt <= '0;
      stall_cnt <= '0;
      credit_err <= 1'b0;
    end else begin
      upd_q <= upd_hit;
      credit_cnt <= over ? CREDIT_MAX : credit_sum[CREDIT_BITS-1:0];
      credit_err <= credit_err || over;
      if (load) begin
        packet_out <= {1'b1, out_control_reg, self_leaf, PORT_ID, bram_addr, {PAD_BITS{1'b0}},
                       PAYLOAD_BITS'(fifo_dout)};
        bram_addr <= bram_addr + 1'b1;
      end
      state <= load ? ST_SEND : (packet_out_ack ? ST_IDLE : state);
      sent_cnt <= sent_cnt + PAYLOAD_BITS'(state == ST_SEND && packet_out_ack);
      stall_cnt <= stall_cnt + PAYLOAD_BITS'(output_port_stall_condition);
    end
endmodule

// File: tb/tb_output_port_credit_tx.sv
// tb_output_port_credit_tx: self-checking bench for output_port_credit_tx
module tb_output_port_credit_tx;
  localparam logic [5:0] SELF = 6'd5;
  localparam logic [5:0] DL = 6'd9;
  localparam logic [3:0] DP = 4'd3;
  localparam logic [3:0] MYPORT = 4'd2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] self_leaf;
  logic [9:0] out_control_reg;
  logic [31:0] din_user;
  logic vld_user2b_out, ack_b_out2user;
  logic [96:0] stream_in, packet_out;
  logic packet_out_vld, packet_out_ack;
  logic [7:0] credit_cnt;
  logic [63:0] sent_cnt, stall_cnt;
  logic output_port_stall_condition, credit_err;
  int n_chk = 0;
  int n_fail = 0;
  logic [96:0] exp_q[$];
  logic [6:0] exp_addr;
  typedef struct {
    logic v;
    logic [5:0] dl;
    logic [3:0] dp;
    logic [5:0] sl;
    logic [3:0] sp;
    logic [7:0] exp_credit;
    logic exp_err;
  } vec_t;
  vec_t vt[6];

  always #5 clk = ~clk;

  output_port_credit_tx dut (
    .clk(clk),
    .reset(reset),
    .self_leaf(self_leaf),
    .out_control_reg(out_control_reg),
    .din_user(din_user),
    .vld_user2b_out(vld_user2b_out),
    .ack_b_out2user(ack_b_out2user),
    .stream_in(stream_in),
    .packet_out(packet_out),
    .packet_out_vld(packet_out_vld),
    .packet_out_ack(packet_out_ack),
    .credit_cnt(credit_cnt),
    .sent_cnt(sent_cnt),
    .stall_cnt(stall_cnt),
    .output_port_stall_condition(output_port_stall_condition),
    .credit_err(credit_err)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [96:0] mk_pkt(input logic [6:0] a, input logic [31:0] d);
    return {1'b1, DL, DP, SELF, MYPORT, a, 5'd0, 32'd0, d};
  endfunction

  function automatic logic [96:0] mk_upd(input logic v, input logic [5:0] dl, input logic [3:0] dp,
                                         input logic [5:0] sl, input logic [3:0] sp);
    return {v, dl, dp, sl, sp, 76'd0};
  endfunction

  // Scoreboard: a transfer happens at the next posedge whenever vld&&ack hold mid-cycle.
  always @(negedge clk)
    if (reset && packet_out_vld && packet_out_ack) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_packet: got %0h expected none", packet_out);
      end else chk("packet", packet_out, exp_q.pop_front());
    end

  task automatic send_beat(input logic [31:0] d);
    bit ok = 0;
    din_user = d;
    vld_user2b_out = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (ack_b_out2user) begin
        exp_q.push_back(mk_pkt(exp_addr, d));
        exp_addr = exp_addr + 7'd1;
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    vld_user2b_out = 1'b0;
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: beat %0h never acknowledged", d);
    end
  endtask

  task automatic wait_drain();
    int i = 0;
    while ((exp_q.size() != 0 || packet_out_vld) && i < 400) begin
      @(posedge clk);
      #2;
      i++;
    end
    n_chk++;
    if (i >= 400) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d packets outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    exp_addr = '0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ack"}, ack_b_out2user, 1'b1);
    chk({tag, "_vld"}, packet_out_vld, 1'b0);
    chk({tag, "_pkt"}, packet_out, 97'd0);
    chk({tag, "_credit"}, credit_cnt, 8'd128);
    chk({tag, "_sent"}, sent_cnt, 64'd0);
    chk({tag, "_stall"}, stall_cnt, 64'd0);
    chk({tag, "_stallcond"}, output_port_stall_condition, 1'b0);
    chk({tag, "_err"}, credit_err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vld_user2b_out = 1'b0;
    din_user = '0;
    stream_in = '0;
    packet_out_ack = 1'b1;
    self_leaf = SELF;
    out_control_reg = {DL, DP};
    exp_addr = '0;
    vt[0] = '{1'b1, SELF, MYPORT, DL, 4'd4, 8'd100, 1'b0};
    vt[1] = '{1'b1, SELF, 4'd1, DL, DP, 8'd100, 1'b0};
    vt[2] = '{1'b1, 6'd6, MYPORT, DL, DP, 8'd100, 1'b0};
    vt[3] = '{1'b1, SELF, MYPORT, 6'd8, DP, 8'd100, 1'b0};
    vt[4] = '{1'b0, SELF, MYPORT, DL, DP, 8'd100, 1'b0};
    vt[5] = '{1'b1, SELF, MYPORT, DL, DP, 8'd128, 1'b1};
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    check_reset("rst");
    // three beats, first valid two cycles after the handshake
    send_beat(32'hA1);
    chk("lat_t1_vld", packet_out_vld, 1'b0);
    send_beat(32'hA2);
    chk("lat_t2_vld", packet_out_vld, 1'b1);
    send_beat(32'hA3);
    wait_drain();
    chk("three_credit", credit_cnt, 8'd125);
    chk("three_sent", sent_cnt, 64'd3);
    // arbiter back-pressure: packet held, no further credit spent
    packet_out_ack = 1'b0;
    send_beat(32'hA4);
    send_beat(32'hA5);
    for (int i = 0; i < 5; i++) begin
      chk("hold_vld", packet_out_vld, 1'b1);
      chk("hold_pkt", packet_out, mk_pkt(7'd3, 32'hA4));
      chk("hold_credit", credit_cnt, 8'd124);
      @(posedge clk);
      #1;
    end
    packet_out_ack = 1'b1;
    wait_drain();
    chk("hold_credit_after", credit_cnt, 8'd123);
    chk("hold_sent", sent_cnt, 64'd5);
    // credit-update filtering table, starting from credit 100
    for (int i = 0; i < 23; i++) send_beat(32'h100 + i);
    wait_drain();
    chk("upd_start_credit", credit_cnt, 8'd100);
    foreach (vt[i]) begin
      stream_in = mk_upd(vt[i].v, vt[i].dl, vt[i].dp, vt[i].sl, vt[i].sp);
      @(posedge clk);
      #1;
      stream_in = '0;
      @(posedge clk);
      #1;
      chk($sformatf("upd%0d_credit", i), credit_cnt, vt[i].exp_credit);
      chk($sformatf("upd%0d_err", i), credit_err, vt[i].exp_err);
    end
    // exhaust credits, stall, then refill with one update
    do_reset();
    chk("rst2_err", credit_err, 1'b0);
    for (int i = 0; i < 128; i++) send_beat(32'h200 + i);
    send_beat(32'hC0DE);
    chk("stall_cond", output_port_stall_condition, 1'b1);
    chk("stall_cnt0", stall_cnt, 64'd0);
    chk("stall_credit0", credit_cnt, 8'd0);
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk);
      #1;
      chk("stall_cnt_inc", stall_cnt, 64'(n));
      chk("stall_vld", packet_out_vld, 1'b0);
    end
    stream_in = mk_upd(1'b1, SELF, MYPORT, DL, DP);
    @(posedge clk);
    #1;
    stream_in = '0;
    chk("stall_cnt5", stall_cnt, 64'd5);
    @(posedge clk);
    #1;
    chk("refill_credit", credit_cnt, 8'd64);
    chk("stall_cnt6", stall_cnt, 64'd6);
    wait_drain();
    chk("refill_credit_after", credit_cnt, 8'd63);
    chk("refill_sent", sent_cnt, 64'd129);
    chk("refill_stall_cnt", stall_cnt, 64'd6);
    chk("refill_stallcond", output_port_stall_condition, 1'b0);
    // update coinciding with a load at credit 10
    for (int i = 0; i < 52; i++) send_beat(32'h300 + i);
    wait_drain();
    chk("co_start_credit", credit_cnt, 8'd11);
    packet_out_ack = 1'b0;
    send_beat(32'hD1);
    send_beat(32'hD2);
    chk("co_pre_credit", credit_cnt, 8'd10);
    stream_in = mk_upd(1'b1, SELF, MYPORT, DL, DP);
    @(posedge clk);
    #1;
    stream_in = '0;
    packet_out_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("co_credit", credit_cnt, 8'd73);
    wait_drain();
    chk("co_sent", sent_cnt, 64'd183);
    chk("co_err", credit_err, 1'b0);
    // fill the FIFO behind a stalled packet, then reset mid-SEND
    packet_out_ack = 1'b0;
    for (int i = 0; i < 16; i++) send_beat(32'h400 + i);
    chk("fill15_ack", ack_b_out2user, 1'b1);
    send_beat(32'h410);
    chk("full_ack", ack_b_out2user, 1'b0);
    chk("full_credit", credit_cnt, 8'd72);
    chk("full_vld", packet_out_vld, 1'b1);
    do_reset();
    check_reset("rst_mid");
    packet_out_ack = 1'b1;
    send_beat(32'hE0);
    wait_drain();
    chk("post_rst_sent", sent_cnt, 64'd1);
    chk("post_rst_credit", credit_cnt, 8'd127);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
